pll_phase_stepper: RTL and testbench
====================================

Name: pll_phase_stepper

Overview:
- Parametrised successor to the single-shot PLL phase setter. Drives the PLL dynamic-phase-shift and clock-switch pins: areset, clkswitch, phasecounterselect, phaseupdown, phasestep, scanclk.
- Adds per-counter selection, relative (bidirectional) stepping from a tracked current phase, and a busy/done/timeout handshake.
- Sits between the register/command decoder and the PLL megafunction.

Parameters:
- PHASE_W, 8: width of target/current phase step counts.
- SCAN_DIV, 16: clk cycles per scanclk half-period.
- STEP_HOLD, 6: scanclk half-periods after which phasestep deasserts.
- MIN_HALFS, 8: minimum half-periods before phase_done is accepted.
- TIMEOUT_HALFS, 108: half-periods after which a step is abandoned.
- ARESET_CYCLES, 8: areset pulse length in clk cycles.
- CLKSWITCH_CYCLES, 8: clkswitch pulse length in clk cycles.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- update  in  1  command strobe; sampled only when busy=0.
- relative  in  1  1: step from current_phase to target, no PLL reset; 0: absolute (areset, then step up from 0).
- pll_clksrc  in  1  absolute mode only: 1 = pulse clkswitch after areset.
- counter_sel  in  3  phasecounterselect value (000 all, 001 M, 010 C0 … 110 C4).
- target_phase  in  PHASE_W  desired phase, in steps.
- phase_done  in  1  PLL phase-done input, asynchronous; internally 2-FF synchronised.
- areset  out  1  PLL reset.
- clkswitch  out  1  PLL clock switch.
- phasecounterselect  out  3  latched counter_sel.
- phaseupdown  out  1  1 = up, 0 = down.
- phasestep  out  1  phase step request.
- scanclk  out  1  divided scan clock.
- busy  out  1  high from accepted update until done.
- done  out  1  one-cycle pulse at command end.
- timeout_err  out  1  set on abort; cleared at next accepted update.
- current_phase  out  PHASE_W  tracked phase (steps from areset).
- steps_taken  out  PHASE_W  steps completed in the current/last command.

Behaviour:
- Reset values (asynchronous, immediate, including mid-operation):
  - areset=0, clkswitch=0, phasecounterselect=0, phaseupdown=1, phasestep=0, scanclk=0.
  - busy=0, done=0, timeout_err=0, current_phase=0, steps_taken=0; state IDLE.
- IDLE:
  - update=1 latches relative, pll_clksrc, counter_sel, target_phase; clears steps_taken and timeout_err; sets busy.
  - Next state: ARESET if relative=0, else SETUP.
  - update while busy=1 is ignored.
- ARESET: areset=1 for ARESET_CYCLES clk cycles, then areset=0 and current_phase=0.
  - Next state: CLKSWITCH if pll_clksrc=1, else SETUP.
- CLKSWITCH: clkswitch=1 for CLKSWITCH_CYCLES cycles, then 0 → SETUP.
- SETUP (1 cycle): diff = target − current_phase, computed signed in PHASE_W+1 bits.
  - phaseupdown = (diff>0); remaining = |diff|; phasecounterselect = latched sel.
  - remaining=0 → FINISH, else STEP.
- STEP entry: scanclk=0, phasestep=1, divider=0, halfs=0. Each clk, divider increments.
- At divider=SCAN_DIV−1: scanclk toggles, divider=0, halfs=halfs+1. With the new halfs value:
  - halfs>=STEP_HOLD: phasestep=0.
  - halfs>=MIN_HALFS and synchronised phase_done=1:
    - steps_taken+1; current_phase ±1 (direction per phaseupdown, modulo 2^PHASE_W); remaining−1.
    - remaining becomes 0 → FINISH, else re-enter STEP.
  - Otherwise, halfs>=TIMEOUT_HALFS: timeout_err=1, phasestep=0 → FINISH. current_phase is not updated for the failed step.
- FINISH (1 cycle): scanclk=0, phasestep=0, done=1, busy=0 → IDLE. done and busy=0 occur in the same cycle.
- phase_done is ignored outside STEP; phaseupdown holds its last value in IDLE.

Test Plan:
- Absolute, target=5, clksrc=0, phase_done tied 1 → areset high exactly 8 cycles; 5 phasestep pulses, each deasserting at halfs=6 (96 clk after assert); phaseupdown=1; done pulse; current_phase=5, steps_taken=5, timeout_err=0.
- Absolute, target=2, clksrc=1 → clkswitch high 8 cycles immediately after areset falls; then 2 steps; current_phase=2.
- Relative, current=5, target=2, counter_sel=010 → no areset; phaseupdown=0, phasecounterselect=010; 3 steps; current_phase=2.
- Relative, target==current=3 → no phasestep or scanclk activity; done pulses within 3 cycles of update.
- Absolute target=4, phase_done held 0 → abort at halfs=108 (1728 clk after step entry); timeout_err=1, steps_taken=0, done pulses. A second update clears timeout_err.
- update asserted while busy → ignored; latched target unchanged. reset during STEP → all outputs at reset values within the same cycle, state IDLE.

Source files
------------

// File: rtl/pll_phase_stepper.sv
// ============================================================================
// Module      : pll_phase_stepper
// Description : PLL dynamic-phase-shift sequencer with absolute/relative
//               stepping, optional clock switch and busy/done/timeout handshake.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module pll_phase_stepper #(
    parameter int PHASE_W          = 8,
    parameter int SCAN_DIV         = 16,
    parameter int STEP_HOLD        = 6,
    parameter int MIN_HALFS        = 8,
    parameter int TIMEOUT_HALFS    = 108,
    parameter int ARESET_CYCLES    = 8,
    parameter int CLKSWITCH_CYCLES = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               update,
    input  logic               relative,
    input  logic               pll_clksrc,
    input  logic [2:0]         counter_sel,
    input  logic [PHASE_W-1:0] target_phase,
    input  logic               phase_done,
    output logic               areset,
    output logic               clkswitch,
    output logic [2:0]         phasecounterselect,
    output logic               phaseupdown,
    output logic               phasestep,
    output logic               scanclk,
    output logic               busy,
    output logic               done,
    output logic               timeout_err,
    output logic [PHASE_W-1:0] current_phase,
    output logic [PHASE_W-1:0] steps_taken
);

    localparam int HALF_W    = $clog2(TIMEOUT_HALFS + 1);
    localparam int DIV_W     = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int PULSE_MAX = (ARESET_CYCLES > CLKSWITCH_CYCLES) ? ARESET_CYCLES : CLKSWITCH_CYCLES;
    localparam int PCNT_W    = (PULSE_MAX > 1) ? $clog2(PULSE_MAX + 1) : 1;

    localparam logic [HALF_W-1:0] c_step_hold   = HALF_W'(STEP_HOLD);
    localparam logic [HALF_W-1:0] c_min_halfs   = HALF_W'(MIN_HALFS);
    localparam logic [HALF_W-1:0] c_timeout     = HALF_W'(TIMEOUT_HALFS);
    localparam logic [DIV_W-1:0]  c_div_last    = DIV_W'(SCAN_DIV - 1);
    localparam logic [PCNT_W-1:0] c_areset_last = PCNT_W'(ARESET_CYCLES - 1);
    localparam logic [PCNT_W-1:0] c_clksw_last  = PCNT_W'(CLKSWITCH_CYCLES - 1);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_ARESET    = 3'd1,
        ST_CLKSWITCH = 3'd2,
        ST_SETUP     = 3'd3,
        ST_STEP      = 3'd4,
        ST_FINISH    = 3'd5
    } state_t;

    state_t             r_state;
    logic               r_clksrc;
    logic [2:0]         r_sel;
    logic [PHASE_W-1:0] r_target;
    logic [PHASE_W-1:0] r_remaining;
    logic [DIV_W-1:0]   r_divider;
    logic [HALF_W-1:0]  r_halfs;
    logic [PCNT_W-1:0]  r_pulse_cnt;
    logic               r_pd_meta;
    logic               r_pd_sync;

    logic [PHASE_W:0]   w_diff;
    logic [PHASE_W-1:0] w_abs;
    logic [HALF_W-1:0]  w_halfs_next;
    logic               w_div_wrap;

    // Signed difference in PHASE_W+1 bits; magnitude always fits PHASE_W bits.
    assign w_diff       = {1'b0, r_target} - {1'b0, current_phase};
    assign w_abs        = w_diff[PHASE_W] ? (current_phase - r_target) : (r_target - current_phase);
    assign w_halfs_next = r_halfs + HALF_W'(1);
    assign w_div_wrap   = (r_divider == c_div_last);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pd_meta <= 1'b0;
            r_pd_sync <= 1'b0;
        end else begin
            r_pd_meta <= phase_done;
            r_pd_sync <= r_pd_meta;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state            <= ST_IDLE;
            r_clksrc           <= 1'b0;
            r_sel              <= 3'd0;
            r_target           <= '0;
            r_remaining        <= '0;
            r_divider          <= '0;
            r_halfs            <= '0;
            r_pulse_cnt        <= '0;
            areset             <= 1'b0;
            clkswitch          <= 1'b0;
            phasecounterselect <= 3'd0;
            phaseupdown        <= 1'b1;
            phasestep          <= 1'b0;
            scanclk            <= 1'b0;
            busy               <= 1'b0;
            done               <= 1'b0;
            timeout_err        <= 1'b0;
            current_phase      <= '0;
            steps_taken        <= '0;
        end else begin
            done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (update) begin
                        r_clksrc    <= pll_clksrc;
                        r_sel       <= counter_sel;
                        r_target    <= target_phase;
                        steps_taken <= '0;
                        timeout_err <= 1'b0;
                        busy        <= 1'b1;
                        r_pulse_cnt <= '0;
                        if (relative) begin
                            r_state <= ST_SETUP;
                        end else begin
                            areset  <= 1'b1;
                            r_state <= ST_ARESET;
                        end
                    end
                end

                ST_ARESET: begin
                    if (r_pulse_cnt == c_areset_last) begin
                        areset        <= 1'b0;
                        current_phase <= '0;
                        r_pulse_cnt   <= '0;
                        if (r_clksrc) begin
                            clkswitch <= 1'b1;
                            r_state   <= ST_CLKSWITCH;
                        end else begin
                            r_state   <= ST_SETUP;
                        end
                    end else begin
                        r_pulse_cnt <= r_pulse_cnt + PCNT_W'(1);
                    end
                end

                ST_CLKSWITCH: begin
                    if (r_pulse_cnt == c_clksw_last) begin
                        clkswitch <= 1'b0;
                        r_state   <= ST_SETUP;
                    end else begin
                        r_pulse_cnt <= r_pulse_cnt + PCNT_W'(1);
                    end
                end

                ST_SETUP: begin
                    phaseupdown        <= !w_diff[PHASE_W] && (w_diff != '0);
                    r_remaining        <= w_abs;
                    phasecounterselect <= r_sel;
                    if (w_abs == '0) begin
                        r_state <= ST_FINISH;
                    end else begin
                        scanclk   <= 1'b0;
                        phasestep <= 1'b1;
                        r_divider <= '0;
                        r_halfs   <= '0;
                        r_state   <= ST_STEP;
                    end
                end

                ST_STEP: begin
                    if (w_div_wrap) begin
                        scanclk   <= ~scanclk;
                        r_divider <= '0;
                        r_halfs   <= w_halfs_next;
                        if (w_halfs_next >= c_step_hold) begin
                            phasestep <= 1'b0;
                        end
                        if ((w_halfs_next >= c_min_halfs) && r_pd_sync) begin
                            steps_taken   <= steps_taken + PHASE_W'(1);
                            current_phase <= phaseupdown ? (current_phase + PHASE_W'(1))
                                                         : (current_phase - PHASE_W'(1));
                            r_remaining   <= r_remaining - PHASE_W'(1);
                            if (r_remaining == PHASE_W'(1)) begin
                                r_state <= ST_FINISH;
                            end else begin
                                // Next step restarts the scan clock and hold window.
                                scanclk   <= 1'b0;
                                phasestep <= 1'b1;
                                r_halfs   <= '0;
                            end
                        end else if (w_halfs_next >= c_timeout) begin
                            timeout_err <= 1'b1;
                            phasestep   <= 1'b0;
                            r_state     <= ST_FINISH;
                        end
                    end else begin
                        r_divider <= r_divider + DIV_W'(1);
                    end
                end

                ST_FINISH: begin
                    scanclk   <= 1'b0;
                    phasestep <= 1'b0;
                    done      <= 1'b1;
                    busy      <= 1'b0;
                    r_state   <= ST_IDLE;
                end

                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_pll_phase_stepper.sv
// ============================================================================
// Module      : tb_pll_phase_stepper
// Description : Scoreboard bench: commands push expected results, a negedge
//               monitor measures pin activity and checks on every done pulse.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_pll_phase_stepper;

    logic       clk = 1'b0;
    logic       reset;
    logic       update;
    logic       relative;
    logic       pll_clksrc;
    logic [2:0] counter_sel;
    logic [7:0] target_phase;
    logic       phase_done;
    logic       areset;
    logic       clkswitch;
    logic [2:0] phasecounterselect;
    logic       phaseupdown;
    logic       phasestep;
    logic       scanclk;
    logic       busy;
    logic       done;
    logic       timeout_err;
    logic [7:0] current_phase;
    logic [7:0] steps_taken;

    pll_phase_stepper dut (
        .clk                (clk),
        .reset              (reset),
        .update             (update),
        .relative           (relative),
        .pll_clksrc         (pll_clksrc),
        .counter_sel        (counter_sel),
        .target_phase       (target_phase),
        .phase_done         (phase_done),
        .areset             (areset),
        .clkswitch          (clkswitch),
        .phasecounterselect (phasecounterselect),
        .phaseupdown        (phaseupdown),
        .phasestep          (phasestep),
        .scanclk            (scanclk),
        .busy               (busy),
        .done               (done),
        .timeout_err        (timeout_err),
        .current_phase      (current_phase),
        .steps_taken        (steps_taken)
    );

    always #5 clk = ~clk;

    typedef struct {
        int cur;
        int steps;
        int terr;
        int updown;
        int sel;
        int aresets;
        int clksws;
        int pulses;
        int toggles;
        int width;
        int r2d;
        int lat;
    } exp_t;

    exp_t q[$];
    int   tests  = 0;
    int   failed = 0;

    task automatic chk(input string name, input int act, input int expv);
        tests++;
        if (act != expv) begin
            failed++;
            $display("FAIL %s: got %0d expected %0d", name, act, expv);
        end
    endtask

    // Monitor state
    int cyc = 0;
    int n_ar, ar_last, n_cs, cs_first, n_ps, rise_cyc, width, n_tg, busy_cyc;
    logic prev_ps = 1'b0, prev_sc = 1'b0, prev_busy = 1'b0;

    task automatic clear_mon();
        n_ar = 0; ar_last = 0; n_cs = 0; cs_first = 0; n_ps = 0;
        rise_cyc = 0; width = 0; n_tg = 0; busy_cyc = 0;
    endtask

    always @(negedge clk) begin
        exp_t e;
        cyc++;
        if (reset) begin
            clear_mon();
        end else begin
            if (busy && !prev_busy) busy_cyc = cyc;
            if (areset) begin n_ar++; ar_last = cyc; end
            if (clkswitch) begin
                if (n_cs == 0) cs_first = cyc;
                n_cs++;
            end
            if (phasestep && !prev_ps) begin
                n_ps++;
                if (n_ps == 1) rise_cyc = cyc;
            end
            if (phasestep && n_ps == 1) width++;
            if (scanclk != prev_sc) n_tg++;
            if (done) begin
                if (q.size() == 0) begin
                    chk("unexpected_done", 1, 0);
                end else begin
                    e = q.pop_front();
                    chk("current_phase", int'(current_phase), e.cur);
                    chk("steps_taken", int'(steps_taken), e.steps);
                    chk("timeout_err", int'(timeout_err), e.terr);
                    chk("phaseupdown", int'(phaseupdown), e.updown);
                    chk("phasecounterselect", int'(phasecounterselect), e.sel);
                    chk("busy_at_done", int'(busy), 0);
                    chk("areset_cycles", n_ar, e.aresets);
                    chk("clkswitch_cycles", n_cs, e.clksws);
                    chk("phasestep_pulses", n_ps, e.pulses);
                    chk("scanclk_toggles", n_tg, e.toggles);
                    if (e.pulses > 0) chk("phasestep_width", width, e.width);
                    if (e.r2d >= 0) chk("step_to_done", cyc - rise_cyc, e.r2d);
                    if (e.lat >= 0) chk("update_to_done", cyc - busy_cyc, e.lat);
                    if (e.clksws > 0) chk("clkswitch_after_areset", cs_first - ar_last, 1);
                end
                clear_mon();
            end
        end
        prev_ps   = phasestep;
        prev_sc   = scanclk;
        prev_busy = busy;
    end

    function automatic exp_t mk(input int cur, input int steps, input int terr, input int updown,
                                input int sel, input int aresets, input int clksws, input int pulses,
                                input int toggles, input int width_v, input int r2d, input int lat);
        exp_t e;
        e.cur = cur; e.steps = steps; e.terr = terr; e.updown = updown; e.sel = sel;
        e.aresets = aresets; e.clksws = clksws; e.pulses = pulses; e.toggles = toggles;
        e.width = width_v; e.r2d = r2d; e.lat = lat;
        return e;
    endfunction

    task automatic issue(input logic rel, input logic src, input logic [2:0] sel, input logic [7:0] tgt);
        @(posedge clk); #2;
        relative     = rel;
        pll_clksrc   = src;
        counter_sel  = sel;
        target_phase = tgt;
        update       = 1'b1;
        @(posedge clk); #2;
        update       = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        int n = 0;
        while (q.size() != 0 && n < 6000) begin
            @(posedge clk);
            n++;
        end
        if (q.size() != 0) begin
            chk({name, "_done_timeout"}, 1, 0);
            q.delete();
        end
        repeat (4) @(posedge clk);
        #2;
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_areset"}, int'(areset), 0);
        chk({tag, "_clkswitch"}, int'(clkswitch), 0);
        chk({tag, "_phasecounterselect"}, int'(phasecounterselect), 0);
        chk({tag, "_phaseupdown"}, int'(phaseupdown), 1);
        chk({tag, "_phasestep"}, int'(phasestep), 0);
        chk({tag, "_scanclk"}, int'(scanclk), 0);
        chk({tag, "_busy"}, int'(busy), 0);
        chk({tag, "_done"}, int'(done), 0);
        chk({tag, "_timeout_err"}, int'(timeout_err), 0);
        chk({tag, "_current_phase"}, int'(current_phase), 0);
        chk({tag, "_steps_taken"}, int'(steps_taken), 0);
    endtask

    initial begin
        int n;
        reset = 1'b1; update = 1'b0; relative = 1'b0; pll_clksrc = 1'b0;
        counter_sel = 3'd0; target_phase = 8'd0; phase_done = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        check_reset_vals("por");
        reset = 1'b0;
        repeat (3) @(posedge clk);

        // Absolute to 5, no clock switch; a busy-time update must be ignored.
        q.push_back(mk(5, 5, 0, 1, 1, 8, 0, 5, 40, 96, 641, -1));
        issue(1'b0, 1'b0, 3'b001, 8'd5);
        repeat (50) @(posedge clk);
        #2;
        relative = 1'b1; target_phase = 8'd9; counter_sel = 3'b111; update = 1'b1;
        @(posedge clk); #2;
        update = 1'b0;
        wait_drain("abs5");

        // Absolute to 2 with clock switch.
        q.push_back(mk(2, 2, 0, 1, 3, 8, 8, 2, 16, 96, 257, -1));
        issue(1'b0, 1'b1, 3'b011, 8'd2);
        wait_drain("abs2_clksw");

        // Relative up 2 -> 5, then down 5 -> 2 on C0.
        q.push_back(mk(5, 3, 0, 1, 0, 0, 0, 3, 24, 96, 385, -1));
        issue(1'b1, 1'b0, 3'b000, 8'd5);
        wait_drain("rel_up");
        q.push_back(mk(2, 3, 0, 0, 2, 0, 0, 3, 24, 96, 385, -1));
        issue(1'b1, 1'b0, 3'b010, 8'd2);
        wait_drain("rel_down");

        // Relative to the current phase: no stepping at all.
        q.push_back(mk(2, 0, 0, 0, 5, 0, 0, 0, 0, 0, -1, 2));
        issue(1'b1, 1'b0, 3'b101, 8'd2);
        wait_drain("rel_equal");

        // Absolute to 4 with phase_done stuck low: abort after 108 half-periods.
        phase_done = 1'b0;
        q.push_back(mk(0, 0, 1, 1, 6, 8, 0, 1, 108, 96, 1729, -1));
        issue(1'b0, 1'b0, 3'b110, 8'd4);
        wait_drain("timeout");

        // Next accepted update clears timeout_err immediately.
        phase_done = 1'b1;
        q.push_back(mk(1, 1, 0, 1, 1, 0, 0, 1, 8, 96, 129, -1));
        issue(1'b1, 1'b0, 3'b001, 8'd1);
        chk("terr_cleared_on_update", int'(timeout_err), 0);
        chk("busy_after_update", int'(busy), 1);
        wait_drain("after_timeout");

        // Asynchronous reset in the middle of a multi-step command.
        issue(1'b1, 1'b0, 3'b011, 8'd4);
        n = 0;
        while (!(phasestep && steps_taken == 8'd1) && n < 2000) begin
            @(posedge clk);
            n++;
        end
        if (n >= 2000) chk("midstep_wait_timeout", 1, 0);
        repeat (20) @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        check_reset_vals("async");
        repeat (2) @(posedge clk);
        #2;
        reset = 1'b0;
        repeat (5) @(posedge clk);

        // Back in IDLE: a no-op relative command completes promptly.
        q.push_back(mk(0, 0, 0, 0, 4, 0, 0, 0, 0, 0, -1, 2));
        issue(1'b1, 1'b0, 3'b100, 8'd0);
        wait_drain("post_reset");

        chk("scoreboard_empty", q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

`default_nettype wire
